// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the word-index PC, captures instructions into an IF/ID
// register with valid/ready hand-off, redirect flush. Optional bound check: PC_FETCH_BOUND_CHECK_EN.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] LAST_PC  = 32'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] instruction,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        cap;

    assign cap = (state_q == FETCH) && (!if_valid_q || id_ready) && !redirect_valid;

    always_comb begin
        // NOTE: every next-state signal starts from its held value so no path leaves it unassigned (no latch).
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        fetch_count_d = fetch_count_q;

        if (redirect_valid) begin
            // Flush wins over decode consuming the in-flight slot.
            pc_d       = redirect_target;
            if_valid_d = 1'b0;
`ifdef PC_FETCH_BOUND_CHECK_EN
            state_d    = (redirect_target > LAST_PC) ? HALT : FETCH;
`endif
        end else if (cap) begin
            if_instr_d    = instruction;
            if_pc_d       = pc_q;
            if_valid_d    = 1'b1;
            fetch_count_d = (fetch_count_q == 32'hFFFF_FFFF) ? fetch_count_q : fetch_count_q + 32'd1;
`ifdef PC_FETCH_BOUND_CHECK_EN
            if (pc_q == LAST_PC) begin
                state_d = HALT;
            end else begin
                pc_d = pc_q + 32'd1;
            end
`else
            pc_d = (pc_q == LAST_PC) ? RESET_PC : pc_q + 32'd1;
`endif
        end else if (if_valid_q && id_ready) begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= 32'd0;
            if_pc_q       <= 32'd0;
            fetch_count_q <= 32'd0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc          = pc_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign fetch_count = fetch_count_q;

`ifdef PC_FETCH_BOUND_CHECK_EN
    assign halted = (state_q == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch front end that owns the program counter driving `instr_reader`. It presents a word-index `pc` each cycle, captures the returned 32-bit instruction into an IF/ID pipeline register, and hands it to decode with a valid/ready handshake. Supports decode back-pressure, branch/jump redirect with flush, and an end-of-program bound.

## Interface
- `RESET_PC`, 0, word index loaded into `pc` on reset
- `LAST_PC`, 2, word index of the final instruction in `instructions.mem`
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous, active-low reset
- `pc`  output  32  word index to `instr_reader`
- `instruction`  input  32  combinational read data from `instr_reader` for current `pc`
- `if_valid`  output  1  IF/ID register holds an instruction
- `if_instr`  output  32  captured instruction
- `if_pc`  output  32  word index the captured instruction came from
- `id_ready`  input  1  decode accepts `if_instr` this cycle
- `redirect_valid`  input  1  branch/jump taken; flush and reload PC
- `redirect_target`  input  32  new word index
- `halted`  output  1  fetch stopped at program bound
- `fetch_count`  output  32  instructions captured since reset, saturating at 0xFFFFFFFF

## Operation
- States: `FETCH`, `HALT`. Reset enters `FETCH`.
- Reset values: `pc`=RESET_PC, `if_valid`=0, `if_instr`=0, `if_pc`=0, `halted`=0, `fetch_count`=0.
- Capture condition (`cap`): state `FETCH` and (`!if_valid` or `id_ready`) and `!redirect_valid`.
- On `cap`: `if_instr`<=`instruction`, `if_pc`<=`pc`, `if_valid`<=1, `fetch_count`+=1 (saturating), `pc` advances (see Configuration).
- Drain without capture: `if_valid` and `id_ready` and not `cap` -> `if_valid`<=0.
- Stall: `if_valid` and `!id_ready` -> `pc`, `if_instr`, `if_pc` hold.
- Redirect (highest priority, any state): `pc`<=`redirect_target`, `if_valid`<=0 (in-flight instruction discarded even if `id_ready`=1 that cycle; decode must not also consume it), no capture, `fetch_count` unchanged. Next state per bound rule below.
- `pc` arithmetic: 32-bit unsigned, +1 per fetch (word index, not byte address).

## Timing
- `instr_reader` is combinational: `instruction` is sampled in the same cycle `pc` is presented.
- Fetch latency: instruction at `pc` appears on `if_instr` with `if_valid`=1 one cycle after `pc` is driven.
- Throughput: one instruction/cycle while `id_ready`=1.
- Redirect: target instruction visible on `if_instr` two cycles after `redirect_valid` is sampled (one bubble).
- `halted` asserted in the same cycle state is `HALT`.
- Reset asserted mid-operation: all outputs return to reset values immediately, independent of `clk`.

## Configuration
- `PC_FETCH_BOUND_CHECK_EN` defined: capture at `pc`==LAST_PC moves to `HALT` with `pc` held at LAST_PC; no further captures; `if_valid` drains normally. Redirect with `redirect_target`<=LAST_PC returns to `FETCH`; target > LAST_PC enters/stays `HALT` with `pc`=target.
- Not defined: `HALT` unreachable, `halted` tied 0; capture at `pc`==LAST_PC loads `pc`<=RESET_PC (wrap); redirect targets beyond LAST_PC are fetched unchecked.

## Test plan
- Reset release, `id_ready`=1, mem {A,B,C}: `if_instr` A,B,C on cycles 1,2,3 with `if_pc` 0,1,2; `fetch_count`=3.
- `id_ready`=0 for cycles 2-4 after A captured: `if_instr`=A, `pc`=1 held; B appears one cycle after `id_ready` returns to 1.
- `redirect_valid`=1, `redirect_target`=0 while `if_valid`=1 (instr B): next cycle `if_valid`=0, `pc`=0; following cycle `if_instr`=A, `fetch_count` not incremented by flushed slot.
- Macro defined, run to end: after C captured `halted`=1, `pc`=2, `fetch_count` stays 3 over 10 further cycles; redirect to 1 clears `halted` and fetches B.
- Macro undefined, run 5 cycles: `if_pc` sequence 0,1,2,0,1; `halted`=0 throughout.
- `rst_n` pulsed low between clock edges mid-run: `if_valid`=0, `pc`=RESET_PC, `fetch_count`=0 before next rising edge.
